// File: rtl/allophone_sequencer_if.sv
// Bus between the allophone sequencer, its phrase ROM and the speech core.
// The master side is the sequencer; the slave side is the ROM plus the speech core.
interface allophone_sequencer_if #(
  parameter int DATA_W = 6,
  parameter int ADDR_W = 8
);
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W:0]   rom_data;
  logic              ldq;
  logic [DATA_W-1:0] data_out;
  logic              data_stb;

  modport master (
    output rom_addr,
    output data_out,
    output data_stb,
    input  rom_data,
    input  ldq
  );

  modport slave (
    input  rom_addr,
    input  data_out,
    input  data_stb,
    output rom_data,
    output ldq
  );
endinterface

// File: rtl/allophone_sequencer.sv
// Walks a phrase in a synchronous ROM and hands each allophone to the speech
// core with a one-cycle strobe. A phrase may loop, be aborted, or time out.
module allophone_sequencer #(
  parameter int DATA_W      = 6,
  parameter int ADDR_W      = 8,
  parameter int CNT_W       = 8,
  parameter int ACK_TIMEOUT = 4096
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [ADDR_W-1:0]    start_addr,
  input  logic                 loop,
  input  logic                 abort,
  allophone_sequencer_if.master bus,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [CNT_W-1:0]     count
);

  // The timer only has to reach ACK_TIMEOUT-1.
  localparam int TMR_W = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LATCH,
    WAIT_RDY,
    STROBE,
    WAIT_ACK
  } state_t;

  state_t state;
  state_t state_n;

  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] phrase_addr;
  logic              loop_r;
  logic              eop_q;
  logic [DATA_W-1:0] data_q;
  logic [TMR_W-1:0]  timer;

  logic load_start;
  logic latch_word;
  logic addr_inc;
  logic addr_restart;
  logic timer_inc;
  logic timeout;
  logic finish;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Abort wins in every busy state; a strobe in progress still completes
  // because data_stb is decoded from the state register.
  always_comb begin
    state_n      = state;
    load_start   = 1'b0;
    latch_word   = 1'b0;
    addr_inc     = 1'b0;
    addr_restart = 1'b0;
    timer_inc    = 1'b0;
    timeout      = 1'b0;
    finish       = 1'b0;
    if (state != IDLE && abort) begin
      finish  = 1'b1;
      state_n = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (start && !abort) begin
            load_start = 1'b1;
            state_n    = FETCH;
          end
        end
        FETCH: begin
          state_n = LATCH;
        end
        LATCH: begin
          latch_word = 1'b1;
          state_n    = WAIT_RDY;
        end
        WAIT_RDY: begin
          if (bus.ldq) begin
            state_n = STROBE;
          end
        end
        STROBE: begin
          state_n = WAIT_ACK;
        end
        WAIT_ACK: begin
          if (!bus.ldq) begin
            if (!eop_q) begin
              addr_inc = 1'b1;
              state_n  = FETCH;
            end else if (loop_r) begin
              addr_restart = 1'b1;
              state_n      = FETCH;
            end else begin
              finish  = 1'b1;
              state_n = IDLE;
            end
          end else begin
            timer_inc = 1'b1;
            if (timer == TMR_W'(ACK_TIMEOUT - 2)) begin
              timeout = 1'b1;
              finish  = 1'b1;
              state_n = IDLE;
            end
          end
        end
        default: begin
          state_n = IDLE;
        end
      endcase
    end
  end

  // Address, phrase context and captured ROM word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr        <= '0;
      phrase_addr <= '0;
      loop_r      <= 1'b0;
      eop_q       <= 1'b0;
      data_q      <= '0;
    end else begin
      if (load_start) begin
        addr        <= start_addr;
        phrase_addr <= start_addr;
        loop_r      <= loop;
      end else if (addr_inc) begin
        addr <= addr + ADDR_W'(1);
      end else if (addr_restart) begin
        addr <= phrase_addr;
      end
      if (latch_word) begin
        data_q <= bus.rom_data[DATA_W-1:0];
        eop_q  <= bus.rom_data[DATA_W];
      end
    end
  end

  // Status: strobe counter, ack timer, sticky error and the done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      timer <= '0;
      err   <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= finish;
      if (load_start) begin
        count <= '0;
        err   <= 1'b0;
      end else if (state == STROBE) begin
        if (count != {CNT_W{1'b1}}) begin
          count <= count + CNT_W'(1);
        end
      end
      if (state == STROBE) begin
        timer <= '0;
      end else if (timer_inc) begin
        timer <= timer + TMR_W'(1);
      end
      if (timeout) begin
        err <= 1'b1;
      end
    end
  end

  assign bus.rom_addr = addr;
  assign bus.data_out = data_q;
  assign bus.data_stb = (state == STROBE);
  assign busy         = (state != IDLE);

endmodule
